// File: rtl/rom_arb_pkg.sv
// Shared types and sizing for the dual-port ROM read arbiter.
// Pointer and tag index width are sized for the largest supported requester
// count, so every legal N_REQ fits the same tag format.
package rom_arb_pkg;

    localparam int N_REQ_MAX = 8;
    localparam int PTR_W     = $clog2(N_REQ_MAX);

    // One in-flight read: which requester the ROM port is returning data to.
    typedef struct packed {
        logic             vld;
        logic [PTR_W-1:0] idx;
    } arb_tag_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin scanner: from a start pointer, finds the first and second set
// bits of a request vector (wrapping modulo N). Purely combinational.
module rr_pick
    import rom_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] start,
    output logic             hit0,
    output logic [PTR_W-1:0] idx0,
    output logic             hit1,
    output logic [PTR_W-1:0] idx1
);

    logic [N_REQ_MAX-1:0] req_ext;
    logic [PTR_W:0]       pos;
    logic [PTR_W-1:0]     j;

    assign req_ext = N_REQ_MAX'(req);

    // Walk start, start+1, ... (mod N) and keep the first two requesters seen.
    always_comb begin
        hit0 = 1'b0;
        idx0 = '0;
        hit1 = 1'b0;
        idx1 = '0;
        pos  = '0;
        j    = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, start} + (PTR_W + 1)'(k);
            if (pos >= (PTR_W + 1)'(N)) begin
                pos = pos - (PTR_W + 1)'(N);
            end
            j = pos[PTR_W-1:0];
            if (req_ext[j]) begin
                if (!hit0) begin
                    hit0 = 1'b1;
                    idx0 = j;
                end else if (!hit1) begin
                    hit1 = 1'b1;
                    idx1 = j;
                end
            end
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares the two synchronous read ports of a dual-port ROM among N_REQ
// requesters, granting up to two requests per cycle in round-robin order
// (port A = first pick, port B = second) and routing returned data back.
// Optional build macro RSP_REG_EN adds an output register on the response
// path (latency 2 instead of 1).
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_valid,
    input  logic [N_REQ*AW-1:0] req_addr,
    output logic [N_REQ-1:0]  req_ready,
    output logic [N_REQ-1:0]  rsp_valid,
    output logic [N_REQ*DW-1:0] rsp_data,
    output logic              en_a,
    output logic [AW-1:0]     add_a,
    output logic              en_b,
    output logic [AW-1:0]     add_b,
    input  logic [DW-1:0]     d_ra,
    input  logic [DW-1:0]     d_rb
);

    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]       last_add_a_q, last_add_a_d;
    logic [AW-1:0]       last_add_b_q, last_add_b_d;
    arb_tag_t            tag_a_q, tag_a_d;
    arb_tag_t            tag_b_q, tag_b_d;
    logic [N_REQ*DW-1:0] data_hold_q, data_hold_d;
    logic [N_REQ-1:0]    rsp_valid_c;
    logic [N_REQ*DW-1:0] rsp_data_c;
    logic                hit0, hit1;
    logic [PTR_W-1:0]    idx0, idx1;
    logic                grant_a, grant_b;
    logic [PTR_W-1:0]    last_idx;

    rr_pick #(.N(N_REQ)) u_pick (
        .req   (req_valid),
        .start (rr_ptr_q),
        .hit0  (hit0),
        .idx0  (idx0),
        .hit1  (hit1),
        .idx1  (idx1)
    );

    // No grants while reset is held, even though req_valid may be toggling.
    assign grant_a = hit0 & rst_n;
    assign grant_b = hit1 & rst_n;

    // Grant decode, ROM port drive and next round-robin pointer.
    always_comb begin
        req_ready = '0;
        en_a      = grant_a;
        en_b      = grant_b;
        add_a     = last_add_a_q;
        add_b     = last_add_b_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_a && (idx0 == PTR_W'(i))) begin
                req_ready[i] = 1'b1;
                add_a        = req_addr[i*AW +: AW];
            end
            if (grant_b && (idx1 == PTR_W'(i))) begin
                req_ready[i] = 1'b1;
                add_b        = req_addr[i*AW +: AW];
            end
        end
        last_add_a_d = add_a;
        last_add_b_d = add_b;

        last_idx = grant_b ? idx1 : idx0;
        rr_ptr_d = rr_ptr_q;
        if (grant_a) begin
            rr_ptr_d = (last_idx == PTR_W'(N_REQ - 1)) ? '0 : last_idx + 1'b1;
        end

        tag_a_d = '{vld: grant_a, idx: idx0};
        tag_b_d = '{vld: grant_b, idx: idx1};
    end

    // Route ROM data to the tagged requesters; other slices keep their value.
    always_comb begin
        rsp_valid_c = '0;
        rsp_data_c  = data_hold_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (tag_a_q.vld && (tag_a_q.idx == PTR_W'(i))) begin
                rsp_valid_c[i]          = 1'b1;
                rsp_data_c[i*DW +: DW]  = d_ra;
            end
            if (tag_b_q.vld && (tag_b_q.idx == PTR_W'(i))) begin
                rsp_valid_c[i]          = 1'b1;
                rsp_data_c[i*DW +: DW]  = d_rb;
            end
        end
        data_hold_d = rsp_data_c;
    end

    // Pointer, held addresses, in-flight tags and last response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            last_add_a_q <= '0;
            last_add_b_q <= '0;
            tag_a_q      <= '0;
            tag_b_q      <= '0;
            data_hold_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            last_add_a_q <= last_add_a_d;
            last_add_b_q <= last_add_b_d;
            tag_a_q      <= tag_a_d;
            tag_b_q      <= tag_b_d;
            data_hold_q  <= data_hold_d;
        end
    end

`ifdef RSP_REG_EN
    logic [N_REQ-1:0] rsp_valid_q;

    // Registered response pulse; data_hold_q already carries the registered data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_c;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = data_hold_q;
`else
    assign rsp_valid = rsp_valid_c;
    assign rsp_data  = rsp_data_c;
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: 1-cycle ROM model (mem[k]=k*3), directed
// cases followed by random traffic, with a scoreboard-based response monitor.
module tb_rom_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 8;
`ifdef RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [N*DW-1:0] rsp_data;
    logic            en_a, en_b;
    logic [AW-1:0]   add_a, add_b;
    logic [DW-1:0]   d_ra = '0;
    logic [DW-1:0]   d_rb = '0;

    rom_read_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .en_a      (en_a),
        .add_a     (add_a),
        .en_b      (en_b),
        .add_b     (add_b),
        .d_ra      (d_ra),
        .d_rb      (d_rb)
    );

    always #5 clk = ~clk;

    // ROM: registered read on each enabled port
    logic [DW-1:0] rom [16];
    initial for (int k = 0; k < 16; k++) rom[k] = DW'(k * 3);
    always @(posedge clk) begin
        if (en_a) d_ra <= rom[add_a];
        if (en_b) d_rb <= rom[add_b];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]    idx;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sb[$];
    int            m_ptr = 0;
    logic [DW-1:0] m_last [N];
    logic [AW-1:0] m_add_a = '0;
    logic [AW-1:0] m_add_b = '0;
    logic [N-1:0]  m_hs = '0;
    int            svc [N];
    int            total = 0;
    int            bad   = 0;

    initial for (int i = 0; i < N; i++) begin
        m_last[i] = '0;
        svc[i]    = 0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ptr   = 0;
        m_add_a = '0;
        m_add_b = '0;
        for (int i = 0; i < N; i++) m_last[i] = '0;
    endtask

    // At the negedge: predict this cycle's grant from the rules, check, enqueue responses.
    task automatic do_cycle();
        int p0, p1;
        logic [1:0]   jj;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        p0 = -1;
        p1 = -1;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                jj = 2'((m_ptr + k) % N);
                if (req_valid[jj]) begin
                    if (p0 < 0) p0 = int'(jj);
                    else if (p1 < 0) p1 = int'(jj);
                end
            end
        end
        exp_rdy = '0;
        if (p0 >= 0) begin
            exp_rdy[p0] = 1'b1;
            m_add_a = req_addr[p0*AW +: AW];
            sb.push_back('{idx: 2'(p0), data: DW'(int'(m_add_a) * 3), due: cyc + LAT});
        end
        if (p1 >= 0) begin
            exp_rdy[p1] = 1'b1;
            m_add_b = req_addr[p1*AW +: AW];
            sb.push_back('{idx: 2'(p1), data: DW'(int'(m_add_b) * 3), due: cyc + LAT});
        end
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("en_a", 64'(en_a), 64'(p0 >= 0));
        check("en_b", 64'(en_b), 64'(p1 >= 0));
        check("add_a", 64'(add_a), 64'(m_add_a));
        check("add_b", 64'(add_b), 64'(m_add_b));
        for (int i = 0; i < N; i++) svc[i] += int'(req_ready[i]);
        if (p1 >= 0) m_ptr = (p1 + 1) % N;
        else if (p0 >= 0) m_ptr = (p0 + 1) % N;
        m_hs = exp_rdy;
        @(posedge clk);
        #1;
    endtask

    // Response monitor: whatever is due this cycle must appear, nothing else.
    always @(negedge clk) begin
        logic [N-1:0]    exp_v;
        logic [N*DW-1:0] exp_d;
        exp_v = '0;
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].due == cyc) begin
                exp_v[sb[k].idx] = 1'b1;
                m_last[sb[k].idx] = sb[k].data;
                sb.delete(k);
            end
        end
        for (int i = 0; i < N; i++) exp_d[i*DW +: DW] = m_last[i];
        check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
        check("rsp_data", 64'(rsp_data), 64'(exp_d));
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        // Reset held with random requests: nothing may be granted or driven
        for (int c = 0; c < 3; c++) begin
            req_valid = N'($urandom);
            req_addr  = (N*AW)'($urandom);
            do_cycle();
        end
        rst_n     = 1'b1;
        req_valid = '0;
        do_cycle();

        // Dual grant from rr_ptr=0: A=req0 addr1, B=req2 addr4
        req_valid = 4'b0101;
        req_addr  = '0;
        req_addr[0*AW +: AW] = 4'd1;
        req_addr[2*AW +: AW] = 4'd4;
        @(negedge clk);
        check("dual_en", 64'({en_a, add_a, en_b, add_b}), 64'({1'b1, 4'd1, 1'b1, 4'd4}));
        @(posedge clk);
        #1;
        req_valid = 4'b0101;
        // step the model through the same cycle without re-waiting the edge
        begin
            int p0 = 0;
            int p1 = 2;
            m_add_a = 4'd1;
            m_add_b = 4'd4;
            sb.push_back('{idx: 2'(p0), data: 8'd3,  due: cyc - 1 + LAT});
            sb.push_back('{idx: 2'(p1), data: 8'd12, due: cyc - 1 + LAT});
            m_ptr = 3;
        end
        req_valid = '0;
        do_cycle();
        do_cycle();

        // Single requester: req1 addr5 (rr_ptr=3 scans 3,0,1)
        req_valid = 4'b0010;
        req_addr[1*AW +: AW] = 4'd5;
        do_cycle();
        req_valid = '0;
        do_cycle();
        do_cycle();

        // Reset one cycle after a grant: the in-flight reads must vanish
        req_valid = 4'b1111;
        req_addr  = (N*AW)'($urandom);
        do_cycle();
        rst_n = 1'b0;
        model_reset();
        do_cycle();
        do_cycle();
        rst_n     = 1'b1;
        req_valid = '0;
        do_cycle();
        do_cycle();
        do_cycle();

        // Fairness: all requesters continuously valid for 4 cycles from rr_ptr=0
        for (int i = 0; i < N; i++) svc[i] = 0;
        for (int c = 0; c < 4; c++) begin
            req_valid = 4'b1111;
            req_addr  = (N*AW)'($urandom);
            do_cycle();
        end
        for (int i = 0; i < N; i++) begin
            check($sformatf("fair_svc%0d", i), 64'(svc[i]), 64'd2);
        end
        req_valid = '0;
        do_cycle();

        // Random traffic obeying the hold-until-ready rule
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_hs[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < 60);
                    req_addr[i*AW +: AW] = AW'($urandom);
                end
            end
            do_cycle();
        end

        // Drain and confirm nothing was left undelivered
        req_valid = '0;
        for (int c = 0; c < 4; c++) do_cycle();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
